// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - AHB burst/transfer/size constants and command arbiter state encoding
package ahb_pkg;

  localparam logic [2:0] BST_SINGLE = 3'd0;
  localparam logic [2:0] BST_INCR   = 3'd1;
  localparam logic [2:0] BST_WRAP4  = 3'd2;
  localparam logic [2:0] BST_INCR4  = 3'd3;
  localparam logic [2:0] BST_WRAP8  = 3'd4;
  localparam logic [2:0] BST_INCR8  = 3'd5;
  localparam logic [2:0] BST_WRAP16 = 3'd6;
  localparam logic [2:0] BST_INCR16 = 3'd7;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_BUSY   = 2'b01;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  localparam logic [2:0] SIZE_BYTE = 3'd0;
  localparam logic [2:0] SIZE_HALF = 3'd1;
  localparam logic [2:0] SIZE_WORD = 3'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CMD    = 2'd1,
    BEAT   = 2'd2,
    RDWAIT = 2'd3
  } arb_state_e;

  // Undefined-length INCR is issued as a single beat by this arbiter.
  function automatic logic [4:0] burst_beats(input logic [2:0] burst);
    logic [4:0] n;
    case (burst)
      BST_WRAP4, BST_INCR4:   n = 5'd4;
      BST_WRAP8, BST_INCR8:   n = 5'd8;
      BST_WRAP16, BST_INCR16: n = 5'd16;
      default:                n = 5'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/ahb_arb_pick.sv
// rtl/ahb_arb_pick.sv - combinational winner pick: search starts at ptr+1 modulo NREQ
module ahb_arb_pick #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      ptr,
  output logic [NREQ-1:0] gnt_oh,
  output logic [1:0]      gnt_idx
);

  // Walk the search order backwards so the earliest candidate overwrites later ones.
  always_comb begin
    gnt_idx = '0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      for (int j = 0; j < NREQ; j++) begin
        if (req[j] && (j == ((int'(ptr) + 1 + off) % NREQ))) gnt_idx = 2'(j);
      end
    end
    gnt_oh = '0;
    for (int j = 0; j < NREQ; j++) gnt_oh[j] = req[j] && (gnt_idx == 2'(j));
  end

endmodule

// File: rtl/ahb_cmd_arbiter.sv
// rtl/ahb_cmd_arbiter.sv - NREQ-to-1 AHB command arbiter with read response routing
// AHB_ARB_RR_EN selects round-robin arbitration; fixed lowest-index priority otherwise.
module ahb_cmd_arbiter
  import ahb_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic [NREQ-1:0]   req_vld_i,
  output logic [NREQ-1:0]   req_rdy_o,
  input  logic [NREQ-1:0]   req_wr_i,
  input  logic [NREQ-1:0]   req_rd_i,
  input  logic [3*NREQ-1:0] req_size_i,
  input  logic [3*NREQ-1:0] req_burst_i,
  input  logic [32*NREQ-1:0] req_addr_i,
  input  logic [32*NREQ-1:0] req_wdata_i,
  output logic [NREQ-1:0]   rsp_vld_o,
  output logic [31:0]       rsp_rdata_o,
  input  logic [NREQ-1:0]   rsp_rdy_i,
  output logic              m_din_vld_o,
  output logic              m_wr_en_o,
  output logic              m_rd_en_o,
  output logic [2:0]        m_data_size_o,
  output logic [2:0]        m_burst_o,
  output logic [31:0]       m_addr_o,
  output logic [31:0]       m_wdata_o,
  output logic              m_dout_rdy_o,
  input  logic              m_din_rdy_i,
  input  logic              m_dout_vld_i,
  input  logic [31:0]       m_rdata_i,
  output logic [1:0]        owner_o
);

  arb_state_e state, state_nxt;
  logic [4:0] cnt, rd_pend, beats;
  logic       is_rd;
  logic [1:0] rr_ptr, win_idx;
  logic [NREQ-1:0] win_oh;
  logic       any_req, cmd_vld, accept, cmd_rd, rd_active, dout_hs;

  logic        sel_vld, sel_wr, sel_rd, sel_rsp_rdy;
  logic [2:0]  sel_size, sel_burst;
  logic [31:0] sel_addr, sel_wdata;

  ahb_arb_pick #(.NREQ(NREQ)) u_pick (
    .req     (req_vld_i),
    .ptr     (rr_ptr),
    .gnt_oh  (win_oh),
    .gnt_idx (win_idx)
  );

  assign any_req = |win_oh;

`ifdef AHB_ARB_RR_EN
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn)                      rr_ptr <= 2'(NREQ - 1);
    else if (state == IDLE && any_req) rr_ptr <= win_idx;
  end
`else
  assign rr_ptr = 2'(NREQ - 1);
`endif

  always_comb begin
    sel_vld     = 1'b0;
    sel_wr      = 1'b0;
    sel_rd      = 1'b0;
    sel_rsp_rdy = 1'b0;
    sel_size    = '0;
    sel_burst   = '0;
    sel_addr    = '0;
    sel_wdata   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_o == 2'(i)) begin
        sel_vld     = req_vld_i[i];
        sel_wr      = req_wr_i[i];
        sel_rd      = req_rd_i[i];
        sel_rsp_rdy = rsp_rdy_i[i];
        sel_size    = req_size_i[3*i +: 3];
        sel_burst   = req_burst_i[3*i +: 3];
        sel_addr    = req_addr_i[32*i +: 32];
        sel_wdata   = req_wdata_i[32*i +: 32];
      end
    end
  end

  // Valid is gated by the owner's request so a withdrawn command can never be accepted.
  assign cmd_vld   = (state == CMD) && sel_vld;
  assign accept    = cmd_vld && m_din_rdy_i;
  assign cmd_rd    = sel_rd && !sel_wr;
  assign beats     = burst_beats(sel_burst);
  assign rd_active = (rd_pend != 5'd0);
  assign dout_hs   = m_dout_vld_i && m_dout_rdy_o;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (any_req) state_nxt = CMD;
      CMD: begin
        if (!sel_vld)               state_nxt = IDLE;
        else if (accept) begin
          if (beats > 5'd1)         state_nxt = BEAT;
          else if (cmd_rd)          state_nxt = RDWAIT;
          else                      state_nxt = IDLE;
        end
      end
      BEAT:   if (m_din_rdy_i && cnt == 5'd1) state_nxt = is_rd ? RDWAIT : IDLE;
      RDWAIT: if (rd_pend == 5'd0 || (rd_pend == 5'd1 && dout_hs)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state   <= IDLE;
      owner_o <= 2'd0;
      cnt     <= 5'd0;
      rd_pend <= 5'd0;
      is_rd   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && any_req) owner_o <= win_idx;
      if (accept) begin
        cnt   <= beats - 5'd1;
        is_rd <= cmd_rd;
      end else if (state == BEAT && m_din_rdy_i) begin
        cnt <= cnt - 5'd1;
      end
      if (accept && cmd_rd) rd_pend <= beats;
      else if (dout_hs)     rd_pend <= rd_pend - 5'd1;
    end
  end

  assign m_din_vld_o   = cmd_vld;
  assign m_wr_en_o     = cmd_vld && sel_wr;
  assign m_rd_en_o     = cmd_vld && cmd_rd;
  assign m_data_size_o = cmd_vld ? sel_size  : 3'd0;
  assign m_burst_o     = cmd_vld ? sel_burst : 3'd0;
  assign m_addr_o      = cmd_vld ? sel_addr  : 32'd0;
  assign m_wdata_o     = cmd_vld ? sel_wdata : 32'd0;
  assign m_dout_rdy_o  = rd_active && sel_rsp_rdy;
  assign rsp_rdata_o   = rd_active ? m_rdata_i : 32'd0;

  always_comb begin
    req_rdy_o = '0;
    rsp_vld_o = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_rdy_o[i] = accept && (owner_o == 2'(i));
      rsp_vld_o[i] = rd_active && m_dout_vld_i && (owner_o == 2'(i));
    end
  end

endmodule

// File: tb/tb_ahb_cmd_arbiter.sv
// tb/tb_ahb_cmd_arbiter.sv - directed table vectors plus multi-cycle sequences for ahb_cmd_arbiter
module tb_ahb_cmd_arbiter;
  import ahb_pkg::*;

  logic        clk = 1'b0;
  logic        hresetn = 1'b0;
  logic [1:0]  req_vld = '0, req_wr = '0, req_rd = '0, rsp_rdy = '0;
  logic [2:0]  b0 = '0, b1 = '0;
  logic        m_din_rdy = 1'b0, m_dout_vld = 1'b0;
  logic [31:0] m_rdata = '0;

  logic [1:0]  req_rdy, rsp_vld, owner;
  logic [31:0] rsp_rdata, m_addr, m_wdata;
  logic        m_din_vld, m_wr_en, m_rd_en, m_dout_rdy;
  logic [2:0]  m_size, m_burst;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ahb_cmd_arbiter #(.NREQ(2)) dut (
    .hclk(clk), .hresetn(hresetn),
    .req_vld_i(req_vld), .req_rdy_o(req_rdy), .req_wr_i(req_wr), .req_rd_i(req_rd),
    .req_size_i({SIZE_WORD, SIZE_WORD}), .req_burst_i({b1, b0}),
    .req_addr_i({32'h0000_0200, 32'h0000_0100}), .req_wdata_i({32'h2222_0000, 32'h1111_0000}),
    .rsp_vld_o(rsp_vld), .rsp_rdata_o(rsp_rdata), .rsp_rdy_i(rsp_rdy),
    .m_din_vld_o(m_din_vld), .m_wr_en_o(m_wr_en), .m_rd_en_o(m_rd_en),
    .m_data_size_o(m_size), .m_burst_o(m_burst), .m_addr_o(m_addr), .m_wdata_o(m_wdata),
    .m_dout_rdy_o(m_dout_rdy), .m_din_rdy_i(m_din_rdy), .m_dout_vld_i(m_dout_vld),
    .m_rdata_i(m_rdata), .owner_o(owner)
  );

  typedef struct {
    logic [1:0] vld, wr, rd; logic [2:0] b0, b1; logic drdy, ovld; logic [31:0] rdata; logic [1:0] rrdy;
    logic [1:0] st, own; logic dvld, wen, ren; logic [1:0] qrdy, svld; logic ordy; logic [31:0] addr, rdat;
  } vec_t;

  vec_t tv [20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req_vld = '0; req_wr = '0; req_rd = '0; rsp_rdy = '0;
    b0 = '0; b1 = '0; m_din_rdy = 1'b0; m_dout_vld = 1'b0; m_rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    hresetn = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    hresetn = 1'b1;
  endtask

  task automatic wait_state(input logic [1:0] s, input string nm);
    int n = 0;
    #1;
    while (dut.state != s && n < 40) begin
      @(negedge clk); #1; n++;
    end
    chk(nm, 32'(dut.state), 32'(s));
  endtask

  logic [1:0] exp_own [4];
  int ones;

  initial begin
    tv[0]  = '{0,0,0,0,0,0,0,0,0,              0,0,0,0,0,0,0,0,0,0};
    tv[1]  = '{1,1,0,0,0,1,0,0,0,              0,0,0,0,0,0,0,0,0,0};
    tv[2]  = '{1,1,0,0,0,1,0,0,0,              1,0,1,1,0,1,0,0,32'h100,0};
    tv[3]  = '{0,0,0,0,0,1,0,0,0,              0,0,0,0,0,0,0,0,0,0};
    tv[4]  = '{2,0,2,0,3,1,0,0,2,              0,0,0,0,0,0,0,0,0,0};
    tv[5]  = '{2,0,2,0,3,1,0,0,2,              1,1,1,0,1,2,0,0,32'h200,0};
    tv[6]  = '{0,0,0,0,3,1,0,0,2,              2,1,0,0,0,0,0,1,0,0};
    tv[7]  = '{0,0,0,0,3,1,0,0,2,              2,1,0,0,0,0,0,1,0,0};
    tv[8]  = '{0,0,0,0,3,1,0,0,2,              2,1,0,0,0,0,0,1,0,0};
    tv[9]  = '{0,0,0,0,3,0,1,32'hA,2,          3,1,0,0,0,0,2,1,0,32'hA};
    tv[10] = '{0,0,0,0,3,0,1,32'hB,2,          3,1,0,0,0,0,2,1,0,32'hB};
    tv[11] = '{0,0,0,0,3,0,1,32'hC,2,          3,1,0,0,0,0,2,1,0,32'hC};
    tv[12] = '{0,0,0,0,3,0,1,32'hD,2,          3,1,0,0,0,0,2,1,0,32'hD};
    tv[13] = '{0,0,0,0,3,0,1,32'hE,2,          0,1,0,0,0,0,0,0,0,0};
    tv[14] = '{1,1,0,0,0,0,0,0,0,              0,1,0,0,0,0,0,0,0,0};
    tv[15] = '{0,0,0,0,0,0,0,0,0,              1,0,0,0,0,0,0,0,0,0};
    tv[16] = '{0,0,0,0,0,0,0,0,0,              0,0,0,0,0,0,0,0,0,0};
    tv[17] = '{1,1,1,0,0,1,0,0,0,              0,0,0,0,0,0,0,0,0,0};
    tv[18] = '{1,1,1,0,0,1,0,0,0,              1,0,1,1,0,1,0,0,32'h100,0};
    tv[19] = '{0,0,0,0,0,1,0,0,0,              0,0,0,0,0,0,0,0,0,0};

    // reset state, with requests and read data present
    repeat (2) @(negedge clk);
    req_vld = 2'b11; req_wr = 2'b11; m_din_rdy = 1'b1; m_dout_vld = 1'b1; rsp_rdy = 2'b11;
    #1;
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    chk("rst_owner", 32'(owner), 0);
    chk("rst_outs", {m_din_vld, m_wr_en, m_rd_en, m_dout_rdy, req_rdy, rsp_vld}, 0);
    @(negedge clk);
    idle_inputs();
    hresetn = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      req_vld = tv[i].vld; req_wr = tv[i].wr; req_rd = tv[i].rd; b0 = tv[i].b0; b1 = tv[i].b1;
      m_din_rdy = tv[i].drdy; m_dout_vld = tv[i].ovld; m_rdata = tv[i].rdata; rsp_rdy = tv[i].rrdy;
      #1;
      chk($sformatf("r%0d_state", i), 32'(dut.state), 32'(tv[i].st));
      chk($sformatf("r%0d_owner", i), 32'(owner), 32'(tv[i].own));
      chk($sformatf("r%0d_din_vld", i), 32'(m_din_vld), 32'(tv[i].dvld));
      chk($sformatf("r%0d_wr_en", i), 32'(m_wr_en), 32'(tv[i].wen));
      chk($sformatf("r%0d_rd_en", i), 32'(m_rd_en), 32'(tv[i].ren));
      chk($sformatf("r%0d_req_rdy", i), 32'(req_rdy), 32'(tv[i].qrdy));
      chk($sformatf("r%0d_rsp_vld", i), 32'(rsp_vld), 32'(tv[i].svld));
      chk($sformatf("r%0d_dout_rdy", i), 32'(m_dout_rdy), 32'(tv[i].ordy));
      chk($sformatf("r%0d_addr", i), m_addr, tv[i].addr);
      chk($sformatf("r%0d_rdata", i), rsp_rdata, tv[i].rdat);
    end

    // both requesters hold valid: grant order
`ifdef AHB_ARB_RR_EN
    exp_own = '{2'd0, 2'd1, 2'd0, 2'd1};
`else
    exp_own = '{2'd0, 2'd0, 2'd0, 2'd0};
`endif
    do_reset();
    req_vld = 2'b11; req_wr = 2'b11; m_din_rdy = 1'b1;
    for (int g = 0; g < 4; g++) begin
      wait_state(CMD, $sformatf("arb_g%0d_cmd", g));
      chk($sformatf("arb_g%0d_owner", g), 32'(owner), 32'(exp_own[g]));
      chk($sformatf("arb_g%0d_req_rdy", g), 32'(req_rdy), 32'(2'b01) << exp_own[g]);
      @(negedge clk);
    end

    // WRAP8 with mid-burst stall while req1 waits
    do_reset();
    req_vld = 2'b11; req_wr = 2'b11; b0 = BST_WRAP8; b1 = BST_SINGLE; m_din_rdy = 1'b1;
    wait_state(CMD, "w8_cmd");
    chk("w8_owner_cmd", 32'(owner), 0);
    ones = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      req_vld = 2'b10;
      m_din_rdy = (c >= 2 && c <= 4) ? 1'b0 : 1'b1;
      #1;
      chk($sformatf("w8_c%0d_state", c), 32'(dut.state), 32'(BEAT));
      chk($sformatf("w8_c%0d_owner", c), 32'(owner), 0);
      if (m_din_rdy) ones++;
    end
    chk("w8_beats", 32'(ones), 7);
    @(negedge clk); #1;
    chk("w8_idle", 32'(dut.state), 32'(IDLE));
    @(negedge clk); #1;
    chk("w8_next_cmd", 32'(dut.state), 32'(CMD));
    chk("w8_next_owner", 32'(owner), 1);

    // read INCR4 with response stall on beat 2
    do_reset();
    req_vld = 2'b10; req_rd = 2'b10; b1 = BST_INCR4; m_din_rdy = 1'b1; rsp_rdy = 2'b10;
    wait_state(CMD, "stl_cmd");
    @(negedge clk);
    req_vld = 2'b00;
    wait_state(RDWAIT, "stl_rdwait");
    @(negedge clk);
    m_dout_vld = 1'b1; m_rdata = 32'hA; #1;
    chk("stl_b1_vld", 32'(rsp_vld), 32'(2'b10));
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      m_rdata = 32'hB; rsp_rdy = 2'b00; #1;
      chk($sformatf("stl_c%0d_state", c), 32'(dut.state), 32'(RDWAIT));
      chk($sformatf("stl_c%0d_dout_rdy", c), 32'(m_dout_rdy), 0);
      chk($sformatf("stl_c%0d_rd_pend", c), 32'(dut.rd_pend), 3);
    end
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      rsp_rdy = 2'b10; m_rdata = 32'hB + 32'(b); #1;
      chk($sformatf("stl_b%0d_data", b + 2), rsp_rdata, 32'hB + 32'(b));
    end
    @(negedge clk);
    m_dout_vld = 1'b0; #1;
    chk("stl_done", 32'(dut.state), 32'(IDLE));

    // asynchronous reset during a read burst
    do_reset();
    req_vld = 2'b10; req_rd = 2'b10; b1 = BST_INCR4; m_din_rdy = 1'b1; rsp_rdy = 2'b10;
    wait_state(CMD, "ar_cmd");
    @(negedge clk);
    m_dout_vld = 1'b1; m_rdata = 32'h55; #1;
    chk("ar_beat", 32'(dut.state), 32'(BEAT));
    chk("ar_rsp_pre", 32'(rsp_vld), 32'(2'b10));
    #1 hresetn = 1'b0;
    #1;
    chk("ar_state", 32'(dut.state), 32'(IDLE));
    chk("ar_owner", 32'(owner), 0);
    chk("ar_ctl", {m_din_vld, m_wr_en, m_rd_en, m_dout_rdy, req_rdy, rsp_vld, m_size, m_burst}, 0);
    chk("ar_addr", m_addr | m_wdata | rsp_rdata, 0);
    @(negedge clk);
    req_vld = 2'b00; hresetn = 1'b1;
    @(negedge clk); #1;
    chk("ar_no_rsp", 32'(rsp_vld), 0);
    chk("ar_idle", 32'(dut.state), 32'(IDLE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
